// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Define MULTI_CYCLE_CTRL_ADDI_EN to decode addi through ADDI_EX/ADDI_WB; otherwise addi is illegal.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
        ,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
`endif
    } state_t;

    state_t cur_state;
    state_t next_state;
    state_t view_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // While in reset the decoder sees FETCH so selects show FETCH values.
    assign view_state = rst_n ? cur_state : FETCH;
    assign state      = view_state;

    always_comb begin
        next_state    = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (view_state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
                    OP_ADDI:      next_state = ADDI_EX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = RTYPE_WB;
            end
            RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_state    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                next_state = FETCH;
            end
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
            ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
`endif
            default: next_state = FETCH;
        endcase

        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: instruction-level path model checked every cycle plus literal spot checks.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    int m_state  = 0;
    bit armed    = 1'b0;
    int path[$];

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    function automatic bit supported(input logic [5:0] op);
        bit ok;
        ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

    // Output table per state; layout matches the 'got' concatenation in the compare loop.
    function automatic logic [21:0] model_out(input int s, input logic r, input logic mr,
                                              input logic z, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, ill, pcen;
        logic [1:0] asb, aop, psrc;
        int eff;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        eff = r ? s : 0;
        case (eff)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; ill = !supported(op); end
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        if (!r) {pcw, pcwc, irw, mrd, mwr, rw, ill} = '0;
        pcen = pcw | (pcwc & z);
        return {pcen, pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa,
                asb, aop, psrc, ill, 4'(eff)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the instruction-level model: wait states hold, DECODE loads the remaining path.
    task automatic model_step();
        if (!rst_n) begin
            m_state = 0;
            path.delete();
            armed = 1'b1;
        end else if (armed) begin
            if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
                m_state = m_state;
            end else if (m_state == 0) begin
                m_state = 1;
            end else begin
                if (m_state == 1) begin
                    path.delete();
                    case (opcode)
                        OP_LW:  path = {2, 3, 4};
                        OP_SW:  path = {2, 5};
                        OP_R:   path = {6, 7};
                        OP_BEQ: path = {8};
                        OP_J:   path = {9};
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
                        OP_ADDI: path = {10, 11};
`endif
                        default: ;
                    endcase
                end
                m_state = (path.size() > 0) ? path.pop_front() : 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
        rst_n = r; opcode = op; zero = z; mem_ready = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string name, input int exp);
        chk(name, {28'd0, state}, exp);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                if (armed)
                    chk("model_cmp",
                        {10'd0, pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                         ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                         alu_op, pc_source, illegal_op, state},
                        {10'd0, model_out(m_state, rst_n, mem_ready, zero, opcode)});
            end
        join_none

        // reset held two cycles with mem_ready high
        drive(0, OP_LW, 0, 1);
        tick(); tick();
        st("rst_state", 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_alu_src_b", alu_src_b, 2'b01);
        drive(1, OP_LW, 0, 1);
        chk("rel_mem_read", mem_read, 1);
        chk("rel_ir_write", ir_write, 1);
        chk("rel_pc_en", pc_en, 1);

        // lw, no stalls
        tick(); st("lw_s1", 1);
        tick(); st("lw_s2", 2); chk("lw_s2_rw", reg_write, 0);
        tick(); st("lw_s3", 3); chk("lw_s3_iord", i_or_d, 1);
        tick(); st("lw_s4", 4); chk("lw_s4_rw", reg_write, 1); chk("lw_s4_m2r", mem_to_reg, 1);
        tick(); st("lw_done", 0);

        // fetch stall one cycle, then lw with one MEMRD stall, mem_ready=0 ignored in DECODE
        drive(1, OP_LW, 0, 0);
        chk("fetch_wait_irw", ir_write, 0); chk("fetch_wait_pcen", pc_en, 0);
        tick(); st("fetch_hold", 0);
        drive(1, OP_LW, 0, 1);
        tick(); drive(1, OP_LW, 0, 0); st("lw2_s1", 1);
        tick(); st("lw2_s2", 2);
        tick(); st("lw2_s3", 3);
        tick(); st("lw2_s3_hold", 3); chk("lw2_hold_rd", mem_read, 1);
        drive(1, OP_LW, 0, 1);
        tick(); st("lw2_s4", 4);
        tick(); st("lw2_done", 0);

        // sw with three mem_ready=0 cycles in MEMWR
        drive(1, OP_SW, 0, 1);
        tick(); tick(); st("sw_s2", 2);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, OP_SW, 0, (i == 3));
            st("sw_s5", 5); chk("sw_mw", mem_write, 1);
            tick();
        end
        st("sw_done", 0);

        // beq: zero=1 then zero=0 within BRANCH
        drive(1, OP_BEQ, 0, 1);
        tick(); tick(); drive(1, OP_BEQ, 1, 1);
        st("beq_s8", 8); chk("beq_pcen1", pc_en, 1);
        chk("beq_psrc", pc_source, 2'b01); chk("beq_aluop", alu_op, 2'b01);
        drive(1, OP_BEQ, 0, 1);
        chk("beq_pcen0", pc_en, 0);
        tick(); st("beq_done", 0);

        // R-type then j
        drive(1, OP_R, 0, 1);
        tick(); tick(); st("r_s6", 6); chk("r_aluop", alu_op, 2'b10);
        tick(); st("r_s7", 7); chk("r_regdst", reg_dst, 1); chk("r_rw", reg_write, 1);
        tick(); st("r_done", 0);
        drive(1, OP_J, 0, 1);
        tick(); tick(); st("j_s9", 9); chk("j_psrc", pc_source, 2'b10); chk("j_pcen", pc_en, 1);
        tick(); st("j_done", 0);

        // illegal opcode
        drive(1, OP_BAD, 0, 1);
        tick(); chk("bad_ill", illegal_op, 1);
        tick(); st("bad_done", 0); chk("bad_ill_gone", illegal_op, 0);

        // addi depends on build option
        drive(1, OP_ADDI, 0, 1);
        tick();
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
        chk("addi_ill", illegal_op, 0);
        tick(); st("addi_s10", 10);
        tick(); st("addi_s11", 11); chk("addi_rw", reg_write, 1);
        tick(); st("addi_done", 0);
`else
        chk("addi_ill", illegal_op, 1);
        tick(); st("addi_done", 0);
`endif

        // reset in the middle of a lw at MEMRD: no writeback afterwards
        drive(1, OP_LW, 0, 1);
        tick(); tick(); tick(); st("mid_s3", 3);
        drive(0, OP_LW, 0, 1);
        st("mid_rst_state", 0); chk("mid_rst_rd", mem_read, 0);
        tick(); drive(1, OP_LW, 0, 1);
        st("mid_after", 0); chk("mid_after_rw", reg_write, 0);
        tick(); st("mid_dec", 1);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
